// File: rtl/tanh_pkg.sv
// Shared constants and helpers for the tanh gradient datapath.
// Activations are S.8 in [-1,1); squares are Q.16 in [0,1].
package tanh_pkg;

    localparam int          W_ACT   = 9;
    localparam int          ACT_F   = 8;
    localparam int          W_SQ    = 2 * W_ACT;
    localparam logic [17:0] ONE_Q16 = 18'd65536;
    localparam int          D_SHIFT = 8;

    function automatic logic [W_SQ-1:0] act_sq(
        input logic [W_ACT-1:0] y
    );
        logic signed [W_SQ-1:0] ys;
        ys = {{(W_SQ-W_ACT){y[W_ACT-1]}}, y};
        return ys * ys;
    endfunction

    // 1 - y^2 rounded down to 9 bits; 256 encodes exactly 1.0
    function automatic logic [8:0] act_d9(
        input logic [W_SQ-1:0] sq
    );
        return 9'((ONE_Q16 - sq) >> ACT_F);
    endfunction

endpackage

// File: rtl/tanh_grad_if.sv
// Stream bundle for the tanh gradient block: activation in,
// gradient in, result out, plus the FIFO occupancy.
interface tanh_grad_if
    import tanh_pkg::*;
#(
    parameter int W_G   = 16,
    parameter int DEPTH = 4
);

    logic                     act_valid;
    logic                     act_ready;
    logic [W_ACT-1:0]         act_data;

    logic                     grad_valid;
    logic                     grad_ready;
    logic [W_G-1:0]           grad_data;

    logic                     out_valid;
    logic                     out_ready;
    logic [W_G-1:0]           out_data;

    logic [$clog2(DEPTH):0]   fifo_count;

    modport master (
        output act_valid, act_data,
        output grad_valid, grad_data,
        output out_ready,
        input  act_ready, grad_ready,
        input  out_valid, out_data,
        input  fifo_count
    );

    modport slave (
        input  act_valid, act_data,
        input  grad_valid, grad_data,
        input  out_ready,
        output act_ready, grad_ready,
        output out_valid, out_data,
        output fifo_count
    );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO holding forward activations until the
// matching gradient arrives; flags come from the registered count.
module sync_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           wdata,
    output logic [W-1:0]           rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_cnt;

    logic w_push;
    logic w_pop;

    assign full   = (r_cnt == (AW+1)'(DEPTH));
    assign empty  = (r_cnt == '0);
    assign count  = r_cnt;
    assign rdata  = r_mem[r_rp];

    // full blocks a push even when a pop frees a slot this cycle
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else if (flush) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + AW'(1);
            if (w_pop)  r_rp <= r_rp + AW'(1);
            unique case (1'b1)
                w_push && !w_pop: r_cnt <= r_cnt + (AW+1)'(1);
                !w_push && w_pop: r_cnt <= r_cnt - (AW+1)'(1);
                default:          r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !flush) r_mem[r_wp] <= wdata;
    end

endmodule

// File: rtl/tanh_grad.sv
// Backward pass of tanh: dL/dx = g * (1 - y^2), joining each
// gradient with the oldest stored activation, 2-stage pipeline.
module tanh_grad
    import tanh_pkg::*;
#(
    parameter int W_G   = 16,
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        flush,
    tanh_grad_if.slave  bus
);

    localparam int PW = W_G + 10;

    logic                   w_full;
    logic                   w_empty;
    logic                   w_en;
    logic                   w_fire;
    logic [W_ACT-1:0]       w_y;
    logic [$clog2(DEPTH):0] w_count;

    logic                   r_s1_v;
    logic [W_SQ-1:0]        r_sq;
    logic signed [W_G-1:0]  r_g1;
    logic                   r_s2_v;
    logic [W_G-1:0]         r_out;

    logic [8:0]             w_d9;
    logic signed [PW-1:0]   w_gx;
    logic signed [PW-1:0]   w_dx;
    logic signed [PW-1:0]   w_prod;
    logic [W_G-1:0]         w_res;

    sync_fifo #(
        .W     (W_ACT),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clock),
        .rst_n (resetn),
        .flush (flush),
        .push  (bus.act_valid),
        .pop   (w_fire),
        .wdata (bus.act_data),
        .rdata (w_y),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    // whole pipe advances together; a held output freezes everything
    assign w_en   = !r_s2_v || bus.out_ready;
    assign w_fire = bus.grad_valid && bus.grad_ready;

    assign bus.act_ready  = !w_full;
    assign bus.grad_ready = w_en && !w_empty;
    assign bus.out_valid  = r_s2_v;
    assign bus.out_data   = r_out;
    assign bus.fifo_count = w_count;

    // d9 <= 256 keeps g*d9 >> 8 inside the gradient range
    assign w_d9   = act_d9(r_sq);
    assign w_gx   = {{(PW-W_G){r_g1[W_G-1]}}, r_g1};
    assign w_dx   = {{(PW-9){1'b0}}, w_d9};
    assign w_prod = w_gx * w_dx;
    assign w_res  = W_G'(w_prod >>> D_SHIFT);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_s1_v <= 1'b0;
            r_sq   <= '0;
            r_g1   <= '0;
            r_s2_v <= 1'b0;
            r_out  <= '0;
        end else if (flush) begin
            r_s1_v <= 1'b0;
            r_s2_v <= 1'b0;
        end else if (w_en) begin
            r_s1_v <= w_fire;
            if (w_fire) begin
                r_sq <= act_sq(w_y);
                r_g1 <= bus.grad_data;
            end
            r_s2_v <= r_s1_v;
            if (r_s1_v) r_out <= w_res;
        end
    end

endmodule
